// File: rtl/hpc3_and_sched.sv
// hpc3_and_sched: round-robin share of one HPC3 masked AND gadget; optional HPC3_SCHED_IDLE_ZERO_EN zeroes idle gadget inputs
module hpc3_and_sched #(
  parameter int security_order = 1,
  parameter int NREQ = 4,
  localparam int D = security_order + 1,
  localparam int R = security_order * (security_order + 1),
  localparam int IDW = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_valid,
  output logic [NREQ-1:0] req_ready,
  input  logic [NREQ*D-1:0] req_a,
  input  logic [NREQ*D-1:0] req_b,
  input  logic            rnd_valid,
  output logic            rnd_ready,
  input  logic [R-1:0]    rnd_data,
  output logic [D-1:0]    g_a,
  output logic [D-1:0]    g_b,
  output logic [R-1:0]    g_r,
  input  logic [D-1:0]    g_c,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [IDW-1:0]  rsp_id,
  output logic [D-1:0]    rsp_c
);
  logic [IDW-1:0] last, cand, id_pipe;
  logic found, issue, inflight, credit, pop, rd, wr;
  logic [1:0] occ;
  logic [D-1:0] ca, cb;
  logic [IDW+D-1:0] mem [2];
  // scan farthest-to-nearest so the last hit is the first valid after last
  always_comb begin
    cand = IDW'((int'(last) + 1) % NREQ);
    found = 1'b0;
    for (int i = NREQ; i >= 1; i--) begin
      if (req_valid[(int'(last) + i) % NREQ]) begin
        cand = IDW'((int'(last) + i) % NREQ);
        found = 1'b1;
      end
    end
  end
  assign ca = req_a[int'(cand)*D +: D];
  assign cb = req_b[int'(cand)*D +: D];
  assign rsp_valid = occ != 2'd0;
  assign pop = rsp_valid & rsp_ready;
  // occ + inflight counts every issued-but-unpopped operation
  assign credit = ({1'b0, occ} + {2'b0, inflight}) < (pop ? 3'd3 : 3'd2);
  assign issue = !rst & found & rnd_valid & credit;
  assign req_ready = issue ? (NREQ'(1) << cand) : '0;
  assign rnd_ready = issue;
  assign {rsp_id, rsp_c} = mem[rd];
`ifdef HPC3_SCHED_IDLE_ZERO_EN
  assign g_a = issue ? ca : '0;
  assign g_b = issue ? cb : '0;
  assign g_r = issue ? rnd_data : '0;
`else
  assign g_a = rst ? '0 : ca;
  assign g_b = rst ? '0 : cb;
  assign g_r = rst ? '0 : rnd_data;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      last <= IDW'(NREQ - 1);
      inflight <= 1'b0;
      id_pipe <= '0;
      occ <= 2'd0;
      rd <= 1'b0;
      wr <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        id_pipe <= cand;
        last <= cand;
      end
      if (inflight) begin
        mem[wr] <= {id_pipe, g_c};
        wr <= ~wr;
      end
      if (pop) rd <= ~rd;
      occ <= occ + {1'b0, inflight} - {1'b0, pop};
    end
  end
endmodule

// File: tb/tb_hpc3_and_sched.sv
// tb_hpc3_and_sched: vector table, corner sequences and random traffic against a scoreboard
module tb_hpc3_and_sched;
  localparam int D = 2, R = 2, NREQ = 4, IDW = 2;
  logic clk = 1'b0, rst = 1'b1;
  logic [NREQ-1:0] req_valid = '0, req_ready;
  logic [NREQ*D-1:0] req_a = '0, req_b = '0;
  logic rnd_valid = 1'b0, rnd_ready, rsp_valid, rsp_ready = 1'b1;
  logic [R-1:0] rnd_data = '0, g_r;
  logic [D-1:0] g_a, g_b, g_c, rsp_c;
  logic [IDW-1:0] rsp_id;
  int n_chk = 0, n_fail = 0, cyc = 0, m_last = NREQ - 1, grants;
  logic [NREQ-1:0] last_grant = '0;
  typedef struct { int id; logic p; int t; } ent_t;
  ent_t q[$];
  typedef struct { logic [3:0] rv; logic rnd; logic [3:0] er; } vec_t;
  vec_t tbl [11];

  hpc3_and_sched #(.security_order(1), .NREQ(NREQ)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
    .rnd_data(rnd_data), .g_a(g_a), .g_b(g_b), .g_r(g_r), .g_c(g_c),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_c(rsp_c)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // first-order gadget stand-in: 1-cycle latency, output masked by r[0]
  always @(posedge clk) g_c <= {((^g_a) & (^g_b)) ^ g_r[0], g_r[0]};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    int c, sz;
    logic f, pop, credit, ei;
    if (rst) begin
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_rnd_ready", 32'(rnd_ready), 0);
      chk("rst_g", {26'd0, g_a, g_b, g_r}, 0);
      q.delete();
      m_last = NREQ - 1;
      last_grant = '0;
    end else begin
      pop = rsp_valid & rsp_ready;
      chk("rsp_valid", 32'(rsp_valid), 32'(q.size() > 0 && q[0].t <= cyc - 2));
      if (rsp_valid && q.size() > 0) begin
        chk("rsp_id", 32'(rsp_id), 32'(q[0].id));
        chk("rsp_prod", 32'(^rsp_c), 32'(q[0].p));
      end
      sz = q.size() - ((pop && q.size() > 0) ? 1 : 0);
      credit = sz < 2;
      f = 1'b0;
      c = 0;
      for (int i = 1; i <= NREQ && !f; i++)
        if (req_valid[(m_last + i) % NREQ]) begin
          c = (m_last + i) % NREQ;
          f = 1'b1;
        end
      ei = f & rnd_valid & credit;
      chk("req_ready", 32'(req_ready), ei ? (32'd1 << c) : 0);
      chk("rnd_ready", 32'(rnd_ready), 32'(ei));
      if (ei) begin
        chk("g_a", 32'(g_a), 32'(req_a[c*D +: D]));
        chk("g_b", 32'(g_b), 32'(req_b[c*D +: D]));
        chk("g_r", 32'(g_r), 32'(rnd_data));
        q.push_back('{c, (^req_a[c*D +: D]) & (^req_b[c*D +: D]), cyc});
        m_last = c;
      end
      if (pop && q.size() > 0) void'(q.pop_front());
      last_grant = req_ready;
    end
  end

  initial begin
    tbl = '{
      '{4'b0001, 1'b1, 4'b0001}, '{4'b1111, 1'b1, 4'b0010}, '{4'b1111, 1'b1, 4'b0100},
      '{4'b1111, 1'b1, 4'b1000}, '{4'b1111, 1'b1, 4'b0001}, '{4'b1010, 1'b0, 4'b0000},
      '{4'b1010, 1'b1, 4'b0010}, '{4'b1010, 1'b0, 4'b0000}, '{4'b1010, 1'b1, 4'b1000},
      '{4'b1010, 1'b1, 4'b0010}, '{4'b0000, 1'b1, 4'b0000}};
    repeat (2) step();
    rst = 1'b0;
    // single product: a=01, b=11 -> unmasked 1&0 = 0
    req_valid = 4'b0001; req_a[1:0] = 2'b01; req_b[1:0] = 2'b11; rnd_data = 2'b10; rnd_valid = 1'b1;
    @(negedge clk);
    chk("first_grant", 32'(req_ready), 32'b0001);
    chk("first_rnd", 32'(rnd_ready), 1);
    step();
    req_valid = '0;
    @(negedge clk);
    chk("first_lat1", 32'(rsp_valid), 0);
    step();
    @(negedge clk);
    chk("first_valid", 32'(rsp_valid), 1);
    chk("first_id", 32'(rsp_id), 0);
    chk("first_prod", 32'(^rsp_c), 0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    foreach (tbl[k]) begin
      req_valid = tbl[k].rv; rnd_valid = tbl[k].rnd;
      req_a = NREQ*D'($urandom); req_b = NREQ*D'($urandom); rnd_data = R'($urandom);
      @(negedge clk);
      chk($sformatf("tbl%0d_grant", k), 32'(req_ready), 32'(tbl[k].er));
      chk($sformatf("tbl%0d_rnd", k), 32'(rnd_ready), 32'(|tbl[k].er));
      step();
    end
    repeat (3) step();
    // backpressure: two issues fill the credit, resume on first pop
    rsp_ready = 1'b0; req_valid = 4'b0100; grants = 0;
    repeat (6) begin
      @(negedge clk);
      grants += int'(req_ready[2]);
      step();
    end
    chk("bp_issues", 32'(grants), 2);
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_resume", 32'(req_ready), 32'b0100);
    step();
    req_valid = '0;
    repeat (4) step();
    // reset the cycle after an issue drops that operation
    req_valid = 4'b0001;
    @(negedge clk);
    chk("rst_issue", 32'(req_ready), 32'b0001);
    step();
    rst = 1'b1; req_valid = '0;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", 32'(rsp_valid), 0);
    chk("post_rst_c", {30'd0, rsp_c}, 0);
    step();
    @(negedge clk);
    chk("post_rst_valid2", 32'(rsp_valid), 0);
    step();
    for (int n = 0; n < 10000; n++) begin
      for (int i = 0; i < NREQ; i++)
        if (!req_valid[i] || last_grant[i]) begin
          req_valid[i] = 1'($urandom_range(0, 1));
          req_a[i*D +: D] = D'($urandom);
          req_b[i*D +: D] = D'($urandom);
        end
      rnd_valid = $urandom_range(0, 3) != 0;
      rnd_data = R'($urandom);
      rsp_ready = $urandom_range(0, 3) != 0;
      step();
    end
    req_valid = '0; rsp_ready = 1'b1;
    repeat (5) step();
    chk("drained", 32'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
